// File: rtl/query_tokenizer_if.sv
// Character-in / burst-out bundle between the speech front end, the tokenizer
// and the key encoder's query shift register.
interface query_tokenizer_if #(
    parameter int LENW = 4
);
    logic [7:0]      char_in;
    logic            char_valid;
    logic            char_ready;
    logic [7:0]      datain;
    logic            ice;
    logic            ls;
    logic            word_done;
    logic [LENW-1:0] word_len;
    logic            overflow;

    modport master (
        output char_in, char_valid,
        input  char_ready, datain, ice, ls, word_done, word_len, overflow
    );

    modport slave (
        input  char_in, char_valid,
        output char_ready, datain, ice, ls, word_done, word_len, overflow
    );
endinterface

// File: rtl/query_tokenizer.sv
// Splits a case-folded, filtered ASCII stream into words and replays each word
// as a fixed MAXLEN-byte load/shift burst for the query register.
module query_tokenizer #(
    parameter int         MAXLEN   = 8,
    parameter int         LENW     = 4,
    parameter logic [7:0] PAD_CHAR = 8'h20
) (
    input logic              clk,
    input logic              rst,
    query_tokenizer_if.slave qif
);
    localparam int              IW       = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
    localparam logic [LENW-1:0] LEN_MAX  = LENW'(MAXLEN);
    localparam logic [LENW-1:0] LEN_ONE  = LENW'(1);
    localparam logic [IW-1:0]   IDX_LAST = IW'(MAXLEN - 1);
    localparam logic [IW-1:0]   IDX_ONE  = IW'(1);

    typedef enum logic [1:0] {COLLECT, EMIT, DONE} state_t;

    state_t          state, state_n;
    logic [LENW-1:0] len, len_n;
    logic            ovf, ovf_n;
    logic [IW-1:0]   idx, idx_n;
    logic [7:0]      wbuf [MAXLEN];

    logic            accept, is_upper, is_store, is_delim, wr_en;
    logic [7:0]      folded;

    logic            ready_n, ice_n, ls_n, done_n, ovfo_n;
    logic [7:0]      data_n;
    logic [LENW-1:0] wlen_n;

    assign accept = qif.char_valid & qif.char_ready;

    always_comb begin
        is_upper = qif.char_in inside {[8'h41:8'h5A]};
        is_store = is_upper || (qif.char_in inside {[8'h61:8'h7A], [8'h30:8'h39]});
        is_delim = qif.char_in inside {8'h20, 8'h0A, 8'h0D, 8'h2E, 8'h2C, 8'h3F, 8'h21, 8'h00};
        folded   = is_upper ? qif.char_in + 8'h20 : qif.char_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
            len   <= '0;
            ovf   <= 1'b0;
            idx   <= '0;
        end else begin
            state <= state_n;
            len   <= len_n;
            ovf   <= ovf_n;
            idx   <= idx_n;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) wbuf[len[IW-1:0]] <= folded;
    end

    always_comb begin
        state_n = state;
        len_n   = len;
        ovf_n   = ovf;
        idx_n   = idx;
        wr_en   = 1'b0;
        case (state)
            COLLECT: begin
                if (accept && is_store) begin
                    if (len < LEN_MAX) begin
                        wr_en = 1'b1;
                        len_n = len + LEN_ONE;
                    end else begin
                        ovf_n = 1'b1;
                    end
                end else if (accept && is_delim && len != '0) begin
                    state_n = EMIT;
                    idx_n   = '0;
                end
            end
            EMIT: begin
                if (idx == IDX_LAST) state_n = DONE;
                else                 idx_n   = idx + IDX_ONE;
            end
            DONE: begin
                state_n = COLLECT;
                len_n   = '0;
                ovf_n   = 1'b0;
            end
            default: state_n = COLLECT;
        endcase
    end

    // Outputs are decoded from the next state so the registered burst lines
    // line up with the state they describe rather than lagging it by a cycle.
    always_comb begin
        ready_n = (state_n == COLLECT);
        ice_n   = (state_n == EMIT);
        ls_n    = ice_n && (idx_n == '0);
        data_n  = '0;
        if (ice_n) data_n = (LENW'(idx_n) < len_n) ? wbuf[idx_n] : PAD_CHAR;
        done_n  = (state_n == DONE);
        ovfo_n  = done_n & ovf_n;
        wlen_n  = done_n ? len_n : qif.word_len;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qif.char_ready <= 1'b1;
            qif.datain     <= '0;
            qif.ice        <= 1'b0;
            qif.ls         <= 1'b0;
            qif.word_done  <= 1'b0;
            qif.word_len   <= '0;
            qif.overflow   <= 1'b0;
        end else begin
            qif.char_ready <= ready_n;
            qif.datain     <= data_n;
            qif.ice        <= ice_n;
            qif.ls         <= ls_n;
            qif.word_done  <= done_n;
            qif.word_len   <= wlen_n;
            qif.overflow   <= ovfo_n;
        end
    end
endmodule

// File: tb/tb_query_tokenizer.sv
// Directed and randomized character streams checked cycle by cycle against a
// word-level model that turns accepted characters into an expected output timeline.
module tb_query_tokenizer;
    localparam int MAXLEN = 8;
    localparam int LENW   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    query_tokenizer_if #(.LENW(LENW)) qif ();

    query_tokenizer #(.MAXLEN(MAXLEN), .LENW(LENW), .PAD_CHAR(8'h20)) dut (
        .clk (clk),
        .rst (rst),
        .qif (qif)
    );

    int compared   = 0;
    int mismatched = 0;

    // Model: current word, its overflow flag, and the expected per-cycle
    // {ice, ls, datain, word_done, char_ready} timeline still to come.
    logic [7:0]  word_q[$];
    bit          word_ovf;
    logic [11:0] exp_q[$];
    logic [3:0]  len_q[$];
    bit          ovf_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_accept(input logic [7:0] c);
        logic [7:0] keep;
        bit store;
        store = 1'b1;
        if (c >= "A" && c <= "Z")      keep = c + 8'd32;
        else if (c >= "a" && c <= "z") keep = c;
        else if (c >= "0" && c <= "9") keep = c;
        else begin
            store = 1'b0;
            keep  = 8'h00;
        end
        if (store) begin
            if (word_q.size() < MAXLEN) word_q.push_back(keep);
            else                         word_ovf = 1'b1;
        end else if (c inside {8'h20, 8'h0A, 8'h0D, ".", ",", "?", "!", 8'h00}) begin
            if (word_q.size() > 0) begin
                for (int k = 0; k < MAXLEN; k++)
                    exp_q.push_back({1'b1, (k == 0), (k < word_q.size()) ? word_q[k] : 8'h20, 1'b0, 1'b0});
                exp_q.push_back(12'b0000_0000_0010);
                len_q.push_back(4'(word_q.size()));
                ovf_q.push_back(word_ovf);
                word_q.delete();
                word_ovf = 1'b0;
            end
        end
    endfunction

    task automatic check_cycle(output logic [11:0] e);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = 12'b0000_0000_0001;
        chk("outputs{ice,ls,datain,done,ready}",
            32'({qif.ice, qif.ls, qif.datain, qif.word_done, qif.char_ready}), 32'(e));
        if (e[1]) begin
            chk("word_len", 32'(qif.word_len), 32'(len_q.pop_front()));
            chk("overflow", 32'(qif.overflow), 32'(ovf_q.pop_front()));
        end
    endtask

    task automatic apply_reset();
        qif.char_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        len_q.delete();
        ovf_q.delete();
        word_q.delete();
        word_ovf = 1'b0;
        chk("reset_outputs", 32'({qif.ice, qif.ls, qif.datain, qif.word_done, qif.char_ready}), 32'h001);
        chk("reset_word_len", 32'(qif.word_len), 32'h0);
        chk("reset_overflow", 32'(qif.overflow), 32'h0);
    endtask

    task automatic run_stream(input logic [7:0] s[$], input bit hold, input int abort_emit);
        int pos = 0, cyc = 0, emits = 0;
        bit vld, rdy;
        logic [11:0] e;
        while ((pos < s.size() || exp_q.size() > 0) && cyc < 1000) begin
            vld = (pos < s.size()) && (hold || $urandom_range(0, 3) != 0);
            qif.char_valid = vld;
            qif.char_in    = vld ? s[pos] : 8'($urandom);
            rdy = qif.char_ready;
            @(posedge clk);
            if (vld && rdy) begin
                model_accept(s[pos]);
                pos++;
            end
            #1;
            check_cycle(e);
            cyc++;
            if (e[11]) emits++;
            if (abort_emit > 0 && emits == abort_emit) begin
                apply_reset();
                break;
            end
        end
        qif.char_valid = 1'b0;
        chk("stream_consumed", 32'(pos), 32'(s.size()));
    endtask

    task automatic idle(input int n);
        logic [11:0] e;
        qif.char_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_cycle(e);
        end
    endtask

    function automatic void to_q(input string str, output logic [7:0] q[$]);
        q.delete();
        for (int i = 0; i < str.len(); i++) q.push_back(str[i]);
    endfunction

    function automatic void rand_q(input int n, output logic [7:0] q[$]);
        logic [7:0] dl[8] = '{8'h20, 8'h0A, 8'h0D, 8'h2E, 8'h2C, 8'h3F, 8'h21, 8'h00};
        logic [7:0] jk[5] = '{8'h24, 8'h7E, 8'hC3, 8'h2D, 8'h40};
        int cls;
        q.delete();
        for (int i = 0; i < n; i++) begin
            cls = $urandom_range(0, 11);
            if (cls <= 4)      q.push_back(8'($urandom_range(8'h61, 8'h7A)));
            else if (cls <= 6) q.push_back(8'($urandom_range(8'h41, 8'h5A)));
            else if (cls == 7) q.push_back(8'($urandom_range(8'h30, 8'h39)));
            else if (cls <= 9) q.push_back(dl[$urandom_range(0, 7)]);
            else               q.push_back(jk[$urandom_range(0, 4)]);
        end
        q.push_back(8'h20);
    endfunction

    initial begin
        logic [7:0] q[$];
        word_ovf       = 1'b0;
        qif.char_valid = 1'b0;
        qif.char_in    = 8'h00;
        @(posedge clk);
        apply_reset();
        idle(2);

        to_q("Go ", q);          run_stream(q, 1'b1, 0);
        to_q("  ,,\n", q);       run_stream(q, 1'b0, 0);
        idle(3);
        to_q("abcdefghijk ", q); run_stream(q, 1'b0, 0);
        to_q("x ", q);           run_stream(q, 1'b1, 0);
        to_q("hi there.", q);    run_stream(q, 1'b1, 0);
        to_q("word ", q);        run_stream(q, 1'b1, 4);
        idle(12);
        to_q("ok ", q);          run_stream(q, 1'b1, 0);
        to_q("A1$b?", q);        run_stream(q, 1'b0, 0);

        for (int t = 0; t < 6; t++) begin
            rand_q(40, q);
            run_stream(q, t[0], 0);
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
